// File: rtl/cond_logic.sv
// cond_logic: Execute-stage conditional-execution unit.
//
// Owns the architectural NZCV register. It evaluates the condition field of the
// instruction in Execute, gates that instruction's side effects, and commits flags
// from the two-stage ALU. Those flags arrive one cycle after the producer leaves
// Execute. Flag hazards are resolved by bypass or by a stall request.
//
// Build option: define COND_FLAG_BYPASS_EN to forward alu_flags into the condition
// check. Without it, conditions always read flags_q, and any flag-reading
// conditional instruction stalls while a flag write is pending.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   valid_e, cond_e       Execute instruction valid / condition field
//   flag_w_e              flag write request: [1] = N,Z  [0] = C,V
//   pc_src_e, reg_write_e, mem_write_e   ungated controls from decode
//   stall                 downstream hold; Execute does not advance
//   alu_flags(_vld)       {N,Z,C,V} from ALU stage 2 and its valid
//   flags_q               architectural flags {N,Z,C,V}
//   cond_ex               condition passed for the Execute instruction
//   pc_src, reg_write, mem_write         gated controls
//   stall_req             flag hazard: hold Execute this cycle
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_e,
  input  logic [3:0] cond_e,
  input  logic [1:0] flag_w_e,
  input  logic       pc_src_e,
  input  logic       reg_write_e,
  input  logic       mem_write_e,
  input  logic       stall,
  input  logic [3:0] alu_flags,
  input  logic       alu_flags_vld,
  output logic [3:0] flags_q,
  output logic       cond_ex,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic       stall_req
);

  logic       pend_vld_q, pend_vld_d;
  logic [1:0] pend_mask_q, pend_mask_d;
  logic [3:0] flags_d;

  logic [3:0] wr_bits;
  logic [3:0] merged;
  logic [3:0] eff;
  logic       commit;
  logic       pass;
  logic       reads_flags;
  logic       hazard;
  logic       issue;
  logic       capture;

  always_comb begin
    wr_bits = {{2{pend_mask_q[1]}}, {2{pend_mask_q[0]}}};
    commit  = pend_vld_q & alu_flags_vld;
    merged  = (flags_q & ~wr_bits) | (alu_flags & wr_bits);

`ifdef COND_FLAG_BYPASS_EN
    eff = commit ? merged : flags_q;
`else
    eff = flags_q;
`endif

    // eff = {N,Z,C,V}
    case (cond_e)
      4'b0000: pass = eff[2];
      4'b0001: pass = ~eff[2];
      4'b0010: pass = eff[1];
      4'b0011: pass = ~eff[1];
      4'b0100: pass = eff[3];
      4'b0101: pass = ~eff[3];
      4'b0110: pass = eff[0];
      4'b0111: pass = ~eff[0];
      4'b1000: pass = eff[1] & ~eff[2];
      4'b1001: pass = ~(eff[1] & ~eff[2]);
      4'b1010: pass = (eff[3] == eff[0]);
      4'b1011: pass = (eff[3] != eff[0]);
      4'b1100: pass = ~eff[2] & (eff[3] == eff[0]);
      4'b1101: pass = ~(~eff[2] & (eff[3] == eff[0]));
      default: pass = 1'b1;
    endcase

    // AL and 1111 never look at the flags.
    reads_flags = (cond_e[3:1] != 3'b111);

`ifdef COND_FLAG_BYPASS_EN
    hazard = valid_e & reads_flags & pend_vld_q & ~alu_flags_vld;
`else
    hazard = valid_e & reads_flags & pend_vld_q;
`endif

    stall_req = ~reset & hazard;
    cond_ex   = ~reset & pass;
    issue     = valid_e & cond_ex & ~stall_req;
    pc_src    = pc_src_e & issue;
    reg_write = reg_write_e & issue;
    mem_write = mem_write_e & issue;

    // A held instruction has not left Execute yet, so it must not capture.
    capture = issue & ~stall & (|flag_w_e);

    flags_d     = commit ? merged : flags_q;
    pend_vld_d  = (pend_vld_q & ~commit) | capture;
    pend_mask_d = capture ? flag_w_e : pend_mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      pend_vld_q  <= 1'b0;
      pend_mask_q <= 2'b00;
    end else begin
      flags_q     <= flags_d;
      pend_vld_q  <= pend_vld_d;
      pend_mask_q <= pend_mask_d;
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios followed by random
// traffic, every cycle compared against a behavioural flag/pending model.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_e;
  logic [3:0] cond_e;
  logic [1:0] flag_w_e;
  logic       pc_src_e, reg_write_e, mem_write_e;
  logic       stall;
  logic [3:0] alu_flags;
  logic       alu_flags_vld;
  logic [3:0] flags_q;
  logic       cond_ex, pc_src, reg_write, mem_write, stall_req;

  int n_pass = 0;
  int n_total = 0;

`ifdef COND_FLAG_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  // Reference state: architectural flags plus an outstanding-write record.
  logic [3:0] m_flags = 4'b0000;
  logic       m_pend  = 1'b0;
  logic [1:0] m_mask  = 2'b00;

  always #5 clk = ~clk;

  cond_logic dut (
    .clk          (clk),
    .reset        (reset),
    .valid_e      (valid_e),
    .cond_e       (cond_e),
    .flag_w_e     (flag_w_e),
    .pc_src_e     (pc_src_e),
    .reg_write_e  (reg_write_e),
    .mem_write_e  (mem_write_e),
    .stall        (stall),
    .alu_flags    (alu_flags),
    .alu_flags_vld(alu_flags_vld),
    .flags_q      (flags_q),
    .cond_ex      (cond_ex),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .stall_req    (stall_req)
  );

  // ARM condition semantics: cond[3:1] picks a predicate, cond[0] inverts it.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    base = 1'b1;
    if (c >= 4'd14) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; valid_e = 1'b0; cond_e = 4'b1110; flag_w_e = 2'b00;
    pc_src_e = 1'b0; reg_write_e = 1'b0; mem_write_e = 1'b0; stall = 1'b0;
    alu_flags = 4'b0000; alu_flags_vld = 1'b0;
  endtask

  // Check all outputs against the model for the current inputs, then advance one
  // clock and update the model. Enters and leaves at a falling edge.
  task automatic tick();
    logic [3:0] wmask, merged, f;
    logic       commit, e_stall, e_cond, e_issue, cap;
    #1;
    wmask  = {m_mask[1], m_mask[1], m_mask[0], m_mask[0]};
    commit = m_pend && alu_flags_vld;
    merged = (m_flags & ~wmask) | (alu_flags & wmask);
    f      = (Bypass && commit) ? merged : m_flags;
    e_stall = !reset && valid_e && (cond_e < 4'd14) && m_pend && !(Bypass && alu_flags_vld);
    e_cond  = !reset && ref_pass(cond_e, f);
    e_issue = valid_e && e_cond && !e_stall;
    cap     = e_issue && !stall && (flag_w_e != 2'b00);
    chk4("flags_q", flags_q, m_flags);
    chk1("cond_ex", cond_ex, e_cond);
    chk1("stall_req", stall_req, e_stall);
    chk1("pc_src", pc_src, pc_src_e && e_issue);
    chk1("reg_write", reg_write, reg_write_e && e_issue);
    chk1("mem_write", mem_write, mem_write_e && e_issue);
    @(posedge clk);
    if (reset) begin
      m_flags = 4'b0000; m_pend = 1'b0; m_mask = 2'b00;
    end else begin
      if (commit) begin
        m_flags = merged;
        m_pend  = 1'b0;
      end
      if (cap) begin
        m_pend = 1'b1;
        m_mask = flag_w_e;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    @(negedge clk);

    // Reset with every input high.
    reset = 1'b1; valid_e = 1'b1; cond_e = 4'b1111; flag_w_e = 2'b11;
    pc_src_e = 1'b1; reg_write_e = 1'b1; mem_write_e = 1'b1; stall = 1'b1;
    alu_flags = 4'b1111; alu_flags_vld = 1'b1;
    tick();
    #1;
    chk1("rst_reg_write", reg_write, 1'b0);
    chk1("rst_stall_req", stall_req, 1'b0);
    tick();
    chk4("rst_flags", flags_q, 4'b0000);
    idle(); valid_e = 1'b1; cond_e = 4'b1110; reg_write_e = 1'b1;
    #1 chk1("post_rst_reg_write", reg_write, 1'b1);
    tick();

    // CMP then BEQ.
    idle(); valid_e = 1'b1; flag_w_e = 2'b11;
    tick();
    idle(); valid_e = 1'b1; cond_e = 4'b0000; pc_src_e = 1'b1;
    alu_flags = 4'b0100; alu_flags_vld = 1'b1;
`ifdef COND_FLAG_BYPASS_EN
    #1;
    chk1("beq_bypass_pc_src", pc_src, 1'b1);
    chk1("beq_bypass_stall", stall_req, 1'b0);
    tick();
`else
    #1;
    chk1("beq_stall", stall_req, 1'b1);
    chk1("beq_stalled_pc_src", pc_src, 1'b0);
    tick();
    alu_flags_vld = 1'b0; alu_flags = 4'b0000;
    #1 chk1("beq_retry_pc_src", pc_src, 1'b1);
    tick();
`endif
    chk4("beq_flags", flags_q, 4'b0100);

    // Partial write: reach 1010, then write N,Z only with 0101.
    idle(); valid_e = 1'b1; flag_w_e = 2'b11;
    tick();
    idle(); alu_flags = 4'b1010; alu_flags_vld = 1'b1;
    tick();
    chk4("partial_setup", flags_q, 4'b1010);
    idle(); valid_e = 1'b1; flag_w_e = 2'b10;
    tick();
    idle(); alu_flags = 4'b0101; alu_flags_vld = 1'b1;
    tick();
    chk4("partial_flags", flags_q, 4'b0110);

    // Failed condition captures nothing.
    idle(); reset = 1'b1;
    tick();
    idle(); valid_e = 1'b1; cond_e = 4'b0000; flag_w_e = 2'b11; reg_write_e = 1'b1;
    #1 chk1("fail_reg_write", reg_write, 1'b0);
    tick();
    idle(); alu_flags = 4'b1111; alu_flags_vld = 1'b1;
    tick();
    chk4("fail_flags", flags_q, 4'b0000);

    // ALU late: three cycles of stall on an LT consumer.
    idle(); valid_e = 1'b1; flag_w_e = 2'b11;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); valid_e = 1'b1; cond_e = 4'b1011;
      #1 chk1("late_stall", stall_req, 1'b1);
      tick();
    end
    idle(); valid_e = 1'b1; cond_e = 4'b1011; alu_flags = 4'b1000; alu_flags_vld = 1'b1;
`ifdef COND_FLAG_BYPASS_EN
    #1 chk1("late_bypass_cond_ex", cond_ex, 1'b1);
`endif
    tick();
    idle(); valid_e = 1'b1; cond_e = 4'b1011;
    #1 chk1("late_cond_ex", cond_ex, 1'b1);
    tick();

    // Reset while a write is pending.
    idle(); valid_e = 1'b1; flag_w_e = 2'b11;
    tick();
    idle(); reset = 1'b1;
    tick();
    chk4("midpend_flags", flags_q, 4'b0000);
    idle(); alu_flags = 4'b1111; alu_flags_vld = 1'b1;
    tick();
    chk4("midpend_ignored", flags_q, 4'b0000);
    idle(); valid_e = 1'b1; cond_e = 4'b0000;
    #1 chk1("midpend_no_stall", stall_req, 1'b0);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 39) == 0);
      valid_e       = ($urandom_range(0, 3) != 0);
      cond_e        = 4'($urandom_range(0, 15));
      flag_w_e      = 2'($urandom_range(0, 3));
      pc_src_e      = 1'($urandom_range(0, 1));
      reg_write_e   = 1'($urandom_range(0, 1));
      mem_write_e   = 1'($urandom_range(0, 1));
      stall         = ($urandom_range(0, 4) == 0);
      alu_flags     = 4'($urandom_range(0, 15));
      alu_flags_vld = 1'($urandom_range(0, 1));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
